seg7_mux_driver: RTL and testbench

Parametrised time-multiplexed driver for common-cathode/anode 7-segment displays with N digits, sitting between a core register (or CPU peripheral bus) and the PMOD pins. It decodes a packed hex value, scans one digit at a time with blanking guard bands to prevent ghosting, and double-buffers the displayed value so updates never tear mid-frame. Per-digit enable, decimal points and selectable output polarity are supported.

---
 rtl/seg7_mux_driver_if.sv | 13 +
 rtl/seg7_mux_driver.sv | 198 +++++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_mux_driver_if.sv
// Display-value bus from a core register or CPU peripheral into seg7_mux_driver.
// The master drives value/dp/digit_en and strobes load; the driver is the slave.
interface seg7_mux_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;

    modport master (output value, output dp, output digit_en, output load);
    modport slave  (input  value, input  dp, input  digit_en, input  load);
endinterface

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver with blanking guard bands and frame-aligned double buffering.
// Optional leading-zero blanking is built in when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_mux_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIGIT_CYCLES   = 8192,
    parameter int unsigned BLANK_CYCLES   = 256,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_mux_driver_if.slave      bus,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_start
);
    localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CYC_W  = $clog2(DIGIT_CYCLES);
    localparam int unsigned VAL_W  = 4 * NUM_DIGITS;

    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Zero digits above the most significant enabled non-zero digit; digit 0 always shown.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VAL_W-1:0] v,
                                                      input logic [NUM_DIGITS-1:0] en);
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (en[i] && (v[4*i +: 4] != 4'h0)) seen = 1'b1;
            if (!seen && (v[4*i +: 4] == 4'h0)) m[i] = 1'b1;
        end
        return m;
    endfunction
`endif

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [VAL_W-1:0]      pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [VAL_W-1:0]      disp_value_q, disp_value_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] disp_en_q, disp_en_d;
    logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;
    logic [6:0]            seg_d;
    logic                  seg_dp_d;
    logic [NUM_DIGITS-1:0] dig_sel_d;
    logic                  frame_start_d;

    logic                  boundary;
    logic [3:0]            cur_nib;
    logic                  cur_en, cur_dp, cur_blank;
    logic [NUM_DIGITS-1:0] cur_onehot;
    logic [6:0]            seg_act;
    logic                  dp_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            cyc_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            disp_en_q    <= '0;
            disp_blank_q <= '0;
            seg          <= SEG_OFF;
            seg_dp       <= DP_OFF;
            dig_sel      <= DIG_OFF;
            frame_start  <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            cyc_q        <= cyc_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            disp_value_q <= disp_value_d;
            disp_dp_q    <= disp_dp_d;
            disp_en_q    <= disp_en_d;
            disp_blank_q <= disp_blank_d;
            seg          <= seg_d;
            seg_dp       <= seg_dp_d;
            dig_sel      <= dig_sel_d;
            frame_start  <= frame_start_d;
        end
    end

    always_comb begin
        slot_d        = slot_q;
        cyc_d         = cyc_q;
        pend_value_d  = pend_value_q;
        pend_dp_d     = pend_dp_q;
        pend_en_d     = pend_en_q;
        pend_valid_d  = pend_valid_q;
        disp_value_d  = disp_value_q;
        disp_dp_d     = disp_dp_q;
        disp_en_d     = disp_en_q;
        disp_blank_d  = disp_blank_q;
        seg_d         = SEG_OFF;
        seg_dp_d      = DP_OFF;
        dig_sel_d     = dig_sel;
        frame_start_d = 1'b0;
        cur_nib       = 4'h0;
        cur_en        = 1'b0;
        cur_dp        = 1'b0;
        cur_blank     = 1'b0;
        cur_onehot    = '0;
        seg_act       = 7'h00;
        dp_act        = 1'b0;

        boundary = (slot_q == '0) && (cyc_q == '0);

        if (cyc_q == CYC_W'(DIGIT_CYCLES - 1)) begin
            cyc_d  = '0;
            slot_d = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        // Swap uses the pending set from before this edge; a coincident load lands next frame.
        if (boundary && pend_valid_q) begin
            disp_value_d = pend_value_q;
            disp_dp_d    = pend_dp_q;
            disp_en_d    = pend_en_q;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            disp_blank_d = lz_mask(pend_value_q, pend_en_q);
`else
            disp_blank_d = '0;
`endif
            pend_valid_d = 1'b0;
        end
        if (bus.load) begin
            pend_value_d = bus.value;
            pend_dp_d    = bus.dp;
            pend_en_d    = bus.digit_en;
            pend_valid_d = 1'b1;
        end

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_nib       = disp_value_q[4*i +: 4];
                cur_en        = disp_en_q[i];
                cur_dp        = disp_dp_q[i];
                cur_blank     = disp_blank_q[i];
                cur_onehot[i] = 1'b1;
            end
        end

        frame_start_d = boundary;

        // Cycle 0 of a slot keeps the previous digit select while segments are dark.
        if (cyc_q != '0) begin
            dig_sel_d = cur_en ? cur_onehot : '0;
            if (DIG_ACTIVE_LOW) dig_sel_d = ~dig_sel_d;
        end

        if ((cyc_q >= CYC_W'(BLANK_CYCLES)) && cur_en) begin
            seg_act = cur_blank ? 7'h00 : decode(cur_nib);
            dp_act  = cur_dp;
        end
        seg_d    = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
        seg_dp_d = SEG_ACTIVE_LOW ? ~dp_act : dp_act;
    end
endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver: a cycle model pushes expected pin values each edge,
// compared on the falling edge, plus directed checks of the key display scenarios.
module tb_seg7_mux_driver;
    localparam int ND = 4;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * DC;

    typedef struct packed {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] dig;
        logic          fs;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [6:0]    seg;
    logic          seg_dp;
    logic [ND-1:0] dig_sel;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    logic [6:0] segtab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    seg7_mux_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_mux_driver #(
        .NUM_DIGITS    (ND),
        .DIGIT_CYCLES  (DC),
        .BLANK_CYCLES  (BC),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .dig_sel    (dig_sel),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leading-zero mask computed from the highest enabled non-zero digit.
    function automatic logic [ND-1:0] model_blank(input logic [4*ND-1:0] v, input logic [ND-1:0] en);
        logic [ND-1:0] m;
        int h;
        m = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        h = -1;
        for (int i = 0; i < ND; i++)
            if (en[i] && ((v >> (4 * i)) & 16'hF) != 0) h = i;
        for (int i = 1; i < ND; i++)
            if (i > h && ((v >> (4 * i)) & 16'hF) == 0) m[i] = 1'b1;
`else
        h = 0;
        if (h != 0) m = v[ND-1:0] & en;
`endif
        return m;
    endfunction

    // Reference model: frame position, pending/display buffers and the held digit select.
    int            m_cnt = 0;
    logic          m_pv = 1'b0;
    logic [15:0]   m_pval = '0, m_dval = '0;
    logic [ND-1:0] m_pdp = '0, m_pen = '0, m_ddp = '0, m_den = '0, m_blank = '0;
    logic [ND-1:0] m_dig = '0;

    always @(posedge clk) begin
        exp_t e;
        int s, c;
        logic [6:0] sv;
        logic dv;
        if (rst) begin
            m_cnt = 0; m_pv = 1'b0;
            m_pval = '0; m_pdp = '0; m_pen = '0;
            m_dval = '0; m_ddp = '0; m_den = '0; m_blank = '0;
            m_dig = '0;
            e = '{seg: 7'h7F, dp: 1'b1, dig: '0, fs: 1'b0};
        end else begin
            s = m_cnt / DC;
            c = m_cnt % DC;
            if (m_cnt == 0 && m_pv) begin
                m_dval = m_pval; m_ddp = m_pdp; m_den = m_pen;
                m_blank = model_blank(m_pval, m_pen);
                m_pv = 1'b0;
            end
            if (bus.load) begin
                m_pval = bus.value; m_pdp = bus.dp; m_pen = bus.digit_en; m_pv = 1'b1;
            end
            if (c != 0) m_dig = m_den[s] ? ND'(1 << s) : '0;
            sv = 7'h00;
            dv = 1'b0;
            if (c >= BC && m_den[s]) begin
                sv = m_blank[s] ? 7'h00 : segtab[(m_dval >> (4 * s)) & 16'hF];
                dv = m_ddp[s];
            end
            e = '{seg: ~sv, dp: ~dv, dig: m_dig, fs: (m_cnt == 0)};
            m_cnt = (m_cnt + 1) % FRAME;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_seg", 32'(seg), 32'(e.seg));
            check("sb_seg_dp", 32'(seg_dp), 32'(e.dp));
            check("sb_dig_sel", 32'(dig_sel), 32'(e.dig));
            check("sb_frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [ND-1:0] d, input logic [ND-1:0] en);
        bus.value = v; bus.dp = d; bus.digit_en = en; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Returns at the falling edge where frame_start is observed high.
    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (frame_start !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL wait_frame: frame_start not seen within %0d cycles", 2 * FRAME);
        end
    endtask

    initial begin
        int fs_cnt;
        int bad_dig;
        rst = 1'b1;
        bus.value = '0; bus.dp = '0; bus.digit_en = '0; bus.load = 1'b0;
        cycles(3);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_seg_dp", 32'(seg_dp), 32'h1);
        check("rst_dig_sel", 32'(dig_sel), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        rst = 1'b0;

        fs_cnt = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_cnt++;
        end
        check("frame_start_count", 32'(fs_cnt), 32'd2);

        wait_frame();
        cycles(3);
        do_load(16'h1A3F, 4'h0, 4'hF);
        wait_frame();
        cycles(2);
        check("slot0_seg_F", 32'(seg), 32'(7'b0001110));
        check("slot0_dig_sel", 32'(dig_sel), 32'(4'b0001));
        cycles(24);
        check("slot3_seg_1", 32'(seg), 32'(7'b1111001));
        check("slot3_dig_sel", 32'(dig_sel), 32'(4'b1000));

        wait_frame();
        cycles(16);
        do_load(16'h1111, 4'h0, 4'hF);
        cycles(1);
        check("midframe_keep_A", 32'(seg), 32'(7'b0001000));
        wait_frame();
        cycles(18);
        check("nextframe_new_1", 32'(seg), 32'(7'b1111001));

        cycles(3);
        do_load(16'h5678, 4'b0001, 4'b0101);
        wait_frame();
        bad_dig = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if ((dig_sel & 4'b1010) != 4'b0000) bad_dig++;
        end
        check("disabled_digits_dark", 32'(bad_dig), 32'd0);

        cycles(3);
        do_load(16'h0030, 4'h0, 4'hF);
        wait_frame();
        wait_frame();
        cycles(10);
        check("lz_digit1_is_3", 32'(seg), 32'(7'b0110000));
        cycles(16);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lz_digit3", 32'(seg), 32'h7F);
`else
        check("lz_digit3", 32'(seg), 32'(7'b1000000));
`endif
        check("lz_digit3_sel", 32'(dig_sel), 32'(4'b1000));

        wait_frame();
        cycles(21);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_dig_sel", 32'(dig_sel), 32'h0);
        check("midrst_frame_start", 32'(frame_start), 32'h0);
        rst = 1'b0;
        wait_frame();
        bad_dig = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (dig_sel != 4'b0000 || seg != 7'h7F) bad_dig++;
        end
        check("post_rst_dark", 32'(bad_dig), 32'd0);

        for (int k = 0; k < 6; k++) begin
            do_load(16'($urandom()), 4'($urandom()), 4'($urandom()));
            cycles(int'($urandom_range(20, 70)));
        end
        cycles(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
